input_mem_read_port: RTL and testbench
======================================

// Module: input_mem_read_port
// PURPOSE
//   Upstream stage of the user circuit: owns the input memory buffer and serves the user's
//   req/ack read handshake. The host fills the buffer through a word write port. Accepted user
//   reads return in order, a fixed READ_LATENCY cycles later, as inputMemoryReadDataValid/Data.
//   Host writes win arbitration over user reads.
// PARAMETERS
//   INMEM_BYTE_WIDTH     1   bytes per word; power of 2 >= 1
//   INMEM_ADDRESS_WIDTH  17  word address bits; depth = 2**INMEM_ADDRESS_WIDTH words
//   READ_LATENCY         2   accept-to-valid cycles; legal range 1..4
// PORTS
//   clk                       in   1     clock
//   reset                     in   1     synchronous, active-high
//   hostWriteEn               in   1     host writes hostWriteData to hostWriteAdd this cycle
//   hostWriteAdd              in   AW    host word address
//   hostWriteData             in   8*BW  host write data
//   inputMemoryReadReq        in   1     user read request
//   inputMemoryReadAck        out  1     read accepted when req&&ack in the same cycle
//   inputMemoryReadAdd        in   AW    user read address; sampled in the accept cycle
//   inputMemoryReadDataValid  out  1     returned read data valid, one cycle per accepted read
//   inputMemoryReadData       out  8*BW  returned read data
//   readsAccepted             out  32    count of accepted user reads (status)
//   readsInFlight             out  3     accepted reads not yet returned
// BEHAVIOUR
//   - Reset (sync, active-high): DataValid=0, ReadData=0, readsAccepted=0, readsInFlight=0,
//     ack=0. Valid pipeline flushed; in-flight reads are dropped, never returned. RAM contents kept.
//   - ack is combinational: ack = !reset && !hostWriteEn. It does not depend on req, so the
//     user can see ack before raising req.
//   - Accept cycle t (req&&ack): RAM read of inputMemoryReadAdd issued at t.
//     DataValid=1 with the data at t+READ_LATENCY, exactly one cycle per accept.
//     Back-to-back accepts give back-to-back valids, in order. Throughput is 1 read/cycle.
//   - Host write in cycle t commits at the clk edge ending t. A read accepted at t+1 or later
//     returns the new data.
//   - A read accepted at t returns the old data if the host writes the same address at t+1.
//   - Simultaneous hostWriteEn && inputMemoryReadReq: write proceeds, ack=0, no read accepted.
//     The user must hold req and address.
//   - ReadData is registered; it holds its last value when DataValid=0.
//   - readsAccepted: +1 per accept, wraps 2**32-1 -> 0.
//   - readsInFlight: +1 on accept, -1 on valid, unchanged when both or neither occur;
//     max value = READ_LATENCY.
//   - Address arithmetic is modulo depth; no out-of-range case exists.
//   - Host writes are always accepted, including while the user circuit is running.
//     Ordering between host and user is the software's responsibility.
//   - Pipeline: stage0 = RAM read issue; stages 1..READ_LATENCY-1 = data/valid delay registers.
//     RAM output is registered (latency 1). Extra stages are plain registers.
// STRUCTURE
//   - Shared package/header: MAX_READ_LATENCY=4; the parameter legality check
//     (READ_LATENCY in 1..MAX) fails elaboration via $error/generate.
//   - Sub-module sdp_bram #(WIDTH,ADDR_WIDTH): simple dual-port RAM, one write port, one
//     registered read port, no reset on the array. It must infer block RAM.
//   - Top level holds the arbitration, the valid/data delay line (generate-sized) and the counters.
// TESTING
//   1. Host writes addr 0..7 = 8'h10..8'h17; user reads 0..7 back-to-back with req high ->
//      ack high 8 cycles; valid on cycles t0+2..t0+9, data 8'h10..8'h17 in order;
//      readsAccepted=8.
//   2. hostWriteEn=1 and req=1 in the same cycle (addr 3) -> ack=0 that cycle; read accepted
//      next cycle; data returned equals the just-written value.
//   3. Read addr 5 (holds 8'hAA) at t, host writes 8'h55 to addr 5 at t+1 -> returned data=8'hAA.
//      A re-read returns 8'h55.
//   4. Issue 2 reads, assert reset for 1 cycle before they return -> no DataValid ever seen
//      for them; readsInFlight=0, readsAccepted=0; RAM data intact on the next read.
//   5. Sweep READ_LATENCY=1,2,4 with 16 random-gap reads -> each valid exactly L cycles after
//      its accept; readsInFlight never exceeds L; scoreboard matches.
//   6. Preload readsAccepted via force to 32'hFFFF_FFFF, accept 1 read -> wraps to 0.

Source files
------------

// File: rtl/input_mem_read_port_pkg.sv
// Shared definitions for the input memory read port.
//   MAX_READ_LATENCY   upper bound on the accept-to-valid delay the delay line supports
//   count_t            width of the accepted-read status counter
//   inflight_t         width of the in-flight read counter (holds 0..MAX_READ_LATENCY)
//   readLatencyLegal   elaboration-time check for the READ_LATENCY parameter
//   byteWidthLegal     elaboration-time check for the INMEM_BYTE_WIDTH parameter
package input_mem_read_port_pkg;

  localparam int MAX_READ_LATENCY = 4;
  localparam int COUNT_W          = 32;
  localparam int INFLIGHT_W       = 3;

  typedef logic [COUNT_W-1:0]    count_t;
  typedef logic [INFLIGHT_W-1:0] inflight_t;

  function automatic bit readLatencyLegal(input int lat);
    return (lat >= 1) && (lat <= MAX_READ_LATENCY);
  endfunction

  function automatic bit byteWidthLegal(input int bw);
    return (bw >= 1) && ((bw & (bw - 1)) == 0);
  endfunction

endpackage

// File: rtl/input_mem_read_port_if.sv
// Bus bundle between the input memory read port and its neighbours.
//   Host word write port : hostWriteEn, hostWriteAdd, hostWriteData
//   User read handshake  : inputMemoryReadReq/Ack/Add (request side),
//                          inputMemoryReadDataValid/Data (return side)
//   master modport: used by whoever drives writes and read requests
//   slave modport : used by the memory read port itself
// Parameters must match the ones given to input_mem_read_port.
interface input_mem_read_port_if #(
  parameter int INMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH = 17
);

  localparam int DW = 8 * INMEM_BYTE_WIDTH;
  localparam int AW = INMEM_ADDRESS_WIDTH;

  logic          hostWriteEn;
  logic [AW-1:0] hostWriteAdd;
  logic [DW-1:0] hostWriteData;

  logic          inputMemoryReadReq;
  logic          inputMemoryReadAck;
  logic [AW-1:0] inputMemoryReadAdd;
  logic          inputMemoryReadDataValid;
  logic [DW-1:0] inputMemoryReadData;

  modport master (
    output hostWriteEn, hostWriteAdd, hostWriteData,
    output inputMemoryReadReq, inputMemoryReadAdd,
    input  inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData
  );

  modport slave (
    input  hostWriteEn, hostWriteAdd, hostWriteData,
    input  inputMemoryReadReq, inputMemoryReadAdd,
    output inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData
  );

endinterface

// File: rtl/input_mem_read_port_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk     in   clock
//   reset   in   sync active-high; clears only the read output register
//   wrEn    in   write wrData to wrAdd at the clock edge
//   wrAdd   in   write address
//   wrData  in   write data
//   rdEn    in   load the read register from rdAdd; otherwise it holds
//   rdAdd   in   read address
//   rdData  out  registered read data (latency 1)
// The array has no reset so the tools map it onto block RAM; the output
// register reset maps onto the block RAM output-latch reset.
module sdp_bram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAdd,
  input  logic [WIDTH-1:0]      wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAdd,
  output logic [WIDTH-1:0]      rdData
);

  logic [WIDTH-1:0] ram [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wrEn) ram[wrAdd] <= wrData;
  end

  // Read-before-write: a read and a write to the same address at the same
  // edge return the old word.
  always_ff @(posedge clk) begin
    if (reset)     rdData <= '0;
    else if (rdEn) rdData <= ram[rdAdd];
  end

endmodule

// File: rtl/input_mem_read_port.sv
// Input memory read port: owns the input buffer, accepts host word writes and
// serves the user req/ack read handshake. Accepted reads return in order,
// READ_LATENCY cycles after acceptance, one valid cycle per accepted read.
//   clk            in   clock
//   reset          in   sync active-high; flushes in-flight reads, keeps RAM
//   mem            slave modport of input_mem_read_port_if (host write port,
//                  user read request and read return)
//   readsAccepted  out  32-bit wrapping count of accepted user reads
//   readsInFlight  out  accepted reads not yet returned (0..READ_LATENCY)
module input_mem_read_port
  import input_mem_read_port_pkg::*;
#(
  parameter int INMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH = 17,
  parameter int READ_LATENCY        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input_mem_read_port_if.slave   mem,
  output count_t                 readsAccepted,
  output inflight_t              readsInFlight
);

  localparam int DW = 8 * INMEM_BYTE_WIDTH;
  localparam int AW = INMEM_ADDRESS_WIDTH;

  generate
    if (!readLatencyLegal(READ_LATENCY)) begin : gLatencyCheck
      $error("input_mem_read_port: READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
    end
    if (!byteWidthLegal(INMEM_BYTE_WIDTH)) begin : gByteWidthCheck
      $error("input_mem_read_port: INMEM_BYTE_WIDTH must be a power of 2");
    end
  endgenerate

  // ---- stage 0: arbitration and RAM read issue ----
  // Host writes always win; ack is offered whenever no write is present so the
  // user can see it before raising req.
  logic readVld_p0;

  assign mem.inputMemoryReadAck = !reset && !mem.hostWriteEn;
  assign readVld_p0             = mem.inputMemoryReadReq && mem.inputMemoryReadAck;

  logic [DW-1:0] ramData_p1;

  sdp_bram #(
    .WIDTH      (DW),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (mem.hostWriteEn),
    .wrAdd  (mem.hostWriteAdd),
    .wrData (mem.hostWriteData),
    .rdEn   (readVld_p0),
    .rdAdd  (mem.inputMemoryReadAdd),
    .rdData (ramData_p1)
  );

  // ---- stages 1..READ_LATENCY: valid delay line ----
  logic [READ_LATENCY:1] readVld_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      readVld_p <= '0;
    end else begin
      readVld_p[1] <= readVld_p0;
      for (int k = 2; k <= READ_LATENCY; k++) readVld_p[k] <= readVld_p[k-1];
    end
  end

  // ---- stages 2..READ_LATENCY: data delay line ----
  // Each stage loads only when a valid word passes through, so the last stage
  // (the output) holds its value between returns.
  logic [DW-1:0] readDataOut;

  generate
    if (READ_LATENCY == 1) begin : gNoDelay
      assign readDataOut = ramData_p1;
    end else begin : gDelay
      logic [DW-1:0] delay_p [2:READ_LATENCY];

      always_ff @(posedge clk) begin
        if (readVld_p[1]) delay_p[2] <= ramData_p1;
        for (int k = 3; k <= READ_LATENCY; k++) begin
          if (readVld_p[k-1]) delay_p[k] <= delay_p[k-1];
        end
        if (reset) delay_p[READ_LATENCY] <= '0;
      end

      assign readDataOut = delay_p[READ_LATENCY];
    end
  endgenerate

  logic readRetire;

  assign readRetire                   = readVld_p[READ_LATENCY];
  assign mem.inputMemoryReadDataValid = readRetire;
  assign mem.inputMemoryReadData      = readDataOut;

  // Status counters: an accept and a return in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      readsAccepted <= '0;
      readsInFlight <= '0;
    end else begin
      if (readVld_p0) readsAccepted <= readsAccepted + count_t'(1);
      if (readVld_p0 && !readRetire)      readsInFlight <= readsInFlight + inflight_t'(1);
      else if (!readVld_p0 && readRetire) readsInFlight <= readsInFlight - inflight_t'(1);
    end
  end

endmodule

// File: tb/tb_input_mem_read_port.sv
// Testbench for input_mem_read_port: three instances (READ_LATENCY 1, 2, 4)
// share one stimulus stream; a scoreboard per instance holds expected return
// data and return cycle.
module tb_input_mem_read_port;
  import input_mem_read_port_pkg::*;

  localparam int AW   = 10;
  localparam int BW   = 1;
  localparam int DW   = 8 * BW;
  localparam int NI   = 3;
  localparam int MAIN = 1;   // READ_LATENCY = 2
  localparam int LONG = 2;   // READ_LATENCY = 4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          hostWriteEn;
  logic [AW-1:0] hostWriteAdd;
  logic [DW-1:0] hostWriteData;
  logic          req;
  logic [AW-1:0] rdAdd;

  logic          ack      [NI];
  logic          dv       [NI];
  logic [DW-1:0] rd       [NI];
  count_t        accepted [NI];
  inflight_t     inflight [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : gen
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

      input_mem_read_port_if #(.INMEM_BYTE_WIDTH(BW), .INMEM_ADDRESS_WIDTH(AW)) bus ();

      assign bus.hostWriteEn        = hostWriteEn;
      assign bus.hostWriteAdd       = hostWriteAdd;
      assign bus.hostWriteData      = hostWriteData;
      assign bus.inputMemoryReadReq = req;
      assign bus.inputMemoryReadAdd = rdAdd;
      assign ack[g] = bus.inputMemoryReadAck;
      assign dv[g]  = bus.inputMemoryReadDataValid;
      assign rd[g]  = bus.inputMemoryReadData;

      input_mem_read_port #(
        .INMEM_BYTE_WIDTH    (BW),
        .INMEM_ADDRESS_WIDTH (AW),
        .READ_LATENCY        (L)
      ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (bus),
        .readsAccepted (accepted[g]),
        .readsInFlight (inflight[g])
      );
    end
  endgenerate

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rq;
    logic [AW-1:0] ra;
    logic          expAck;
    logic [DW-1:0] expData;
  } vec_t;

  sb_t           sbq [NI][$];
  int            lat [NI] = '{1, 2, 4};
  logic [DW-1:0] modelMem [0:(2**AW)-1];
  count_t        modelAcc [NI];
  logic [DW-1:0] lastData [NI];
  int            cyc;
  bit            armed;
  bit            useOverride;
  logic [DW-1:0] overrideData;
  int            tests;
  int            fails;

  function void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock: model update at the rising edge, output checks at the falling edge.
  task automatic cycle();
    bit   accept;
    bit   expV;
    sb_t  e;
    @(posedge clk);
    accept = req && !hostWriteEn && !reset;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        sbq[i].delete();
        modelAcc[i] = '0;
        lastData[i] = '0;
      end else if (accept) begin
        e.data = useOverride ? overrideData : modelMem[rdAdd];
        e.due  = cyc + lat[i];
        sbq[i].push_back(e);
        modelAcc[i] = modelAcc[i] + 1;
      end
    end
    if (hostWriteEn) modelMem[hostWriteAdd] = hostWriteData;
    cyc++;
    @(negedge clk);
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("ack_L%0d", lat[i]), ack[i], !reset && !hostWriteEn);
        check($sformatf("readsInFlight_L%0d", lat[i]), inflight[i], sbq[i].size());
        check($sformatf("readsAccepted_L%0d", lat[i]), accepted[i], modelAcc[i]);
        expV = (sbq[i].size() != 0) && (sbq[i][0].due == cyc);
        check($sformatf("dataValid_L%0d", lat[i]), dv[i], expV);
        if (expV) begin
          if (dv[i]) check($sformatf("readData_L%0d", lat[i]), rd[i], sbq[i][0].data);
          void'(sbq[i].pop_front());
        end
        if (dv[i]) lastData[i] = rd[i];
        else       check($sformatf("dataHold_L%0d", lat[i]), rd[i], lastData[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [$];
    vec_t v;
    int   n;
    int   guard;
    bit   wrote;

    tests = 0; fails = 0; cyc = 0; armed = 0; useOverride = 0; overrideData = '0;
    reset = 1'b1; hostWriteEn = 1'b0; hostWriteAdd = '0; hostWriteData = '0;
    req = 1'b0; rdAdd = '0;
    for (int i = 0; i < NI; i++) begin modelAcc[i] = '0; lastData[i] = '0; end

    repeat (3) cycle();

    // Reset state
    for (int i = 0; i < NI; i++) begin
      check("rst_dataValid", dv[i], 1'b0);
      check("rst_readData", rd[i], '0);
      check("rst_readsAccepted", accepted[i], '0);
      check("rst_readsInFlight", inflight[i], '0);
      check("rst_ack_during_reset", ack[i], 1'b0);
    end
    reset = 1'b0;
    armed = 1'b1;
    #1;
    check("ack_after_reset", ack[MAIN], 1'b1);

    // Test 1: table of host writes then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      v = '{we: 1'b1, wa: AW'(i), wd: 8'h10 + 8'(i), rq: 1'b0, ra: '0, expAck: 1'b0, expData: '0};
      vecs.push_back(v);
    end
    for (int i = 0; i < 8; i++) begin
      v = '{we: 1'b0, wa: '0, wd: '0, rq: 1'b1, ra: AW'(i), expAck: 1'b1, expData: 8'h10 + 8'(i)};
      vecs.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{we: 1'b0, wa: '0, wd: '0, rq: 1'b0, ra: '0, expAck: 1'b1, expData: '0};
      vecs.push_back(v);
    end
    foreach (vecs[k]) begin
      hostWriteEn = vecs[k].we; hostWriteAdd = vecs[k].wa; hostWriteData = vecs[k].wd;
      req = vecs[k].rq; rdAdd = vecs[k].ra;
      useOverride = vecs[k].rq; overrideData = vecs[k].expData;
      #1;
      check("tbl_ack", ack[MAIN], vecs[k].expAck);
      cycle();
    end
    useOverride = 0;
    repeat (6) cycle();
    check("tbl_readsAccepted", accepted[MAIN], 32'd8);

    // Test 2: write and read request collide on addr 3
    hostWriteEn = 1'b1; hostWriteAdd = AW'(3); hostWriteData = 8'h3C;
    req = 1'b1; rdAdd = AW'(3);
    #1;
    check("collide_ack", ack[MAIN], 1'b0);
    cycle();
    hostWriteEn = 1'b0; useOverride = 1; overrideData = 8'h3C;
    #1;
    check("collide_retry_ack", ack[MAIN], 1'b1);
    cycle();
    req = 1'b0; useOverride = 0;
    repeat (6) cycle();

    // Test 3: read of addr 5, host overwrites it the next cycle
    hostWriteEn = 1'b1; hostWriteAdd = AW'(5); hostWriteData = 8'hAA;
    cycle();
    hostWriteEn = 1'b0; req = 1'b1; rdAdd = AW'(5); useOverride = 1; overrideData = 8'hAA;
    cycle();
    req = 1'b0; useOverride = 0; hostWriteEn = 1'b1; hostWriteAdd = AW'(5); hostWriteData = 8'h55;
    cycle();
    hostWriteEn = 1'b0;
    repeat (2) cycle();
    req = 1'b1; rdAdd = AW'(5); useOverride = 1; overrideData = 8'h55;
    cycle();
    req = 1'b0; useOverride = 0;
    repeat (6) cycle();

    // Test 4: reset while two reads are in flight
    req = 1'b1; rdAdd = AW'(1); useOverride = 1; overrideData = 8'h11;
    cycle();
    rdAdd = AW'(2); overrideData = 8'h12;
    cycle();
    req = 1'b0; useOverride = 0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("flush_readsInFlight", inflight[LONG], '0);
    check("flush_readsAccepted", accepted[LONG], '0);
    check("flush_dataValid", dv[LONG], 1'b0);
    repeat (6) cycle();
    req = 1'b1; rdAdd = AW'(1); useOverride = 1; overrideData = 8'h11;
    cycle();
    req = 1'b0; useOverride = 0;
    repeat (6) cycle();

    // Test 5: random-gap reads with occasional host writes stalling the request
    n = 0; guard = 0;
    while (n < 16 && guard < 400) begin
      req = 1'b0;
      repeat ($urandom_range(0, 3)) cycle();
      req = 1'b1; rdAdd = AW'($urandom_range(0, 7));
      do begin
        hostWriteEn   = ($urandom_range(0, 4) == 0);
        hostWriteAdd  = AW'($urandom_range(0, 7));
        hostWriteData = DW'($urandom_range(0, 255));
        wrote = hostWriteEn;
        cycle();
        guard++;
      end while (wrote && guard < 400);
      hostWriteEn = 1'b0;
      n++;
    end
    req = 1'b0;
    repeat (8) cycle();

    // Test 6: accepted-read counter wraps
    force gen[MAIN].u_dut.readsAccepted = 32'hFFFF_FFFF;
    #1;
    release gen[MAIN].u_dut.readsAccepted;
    modelAcc[MAIN] = 32'hFFFF_FFFF;
    req = 1'b1; rdAdd = AW'(0);
    cycle();
    req = 1'b0;
    check("wrap_readsAccepted", accepted[MAIN], 32'd0);
    repeat (6) cycle();

    for (int i = 0; i < NI; i++) check($sformatf("scoreboard_empty_L%0d", lat[i]), sbq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
